wb_ram_bridge: RTL and testbench

WB_RAM_BRIDGE -- requirements
Module: wb_ram_bridge

---
 rtl/wb_ram_pkg.sv | 33 +++
 rtl/wb_ram_bridge.sv | 144 ++++++++++++++
 tb/tb_wb_ram_bridge.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_pkg.sv
// rtl/wb_ram_pkg.sv - shared types and helpers for the Wishbone-to-RAM bridge
// Contents:
//   state_t    : bridge FSM states
//   log2       : ceiling log2 used to size address and byte-offset fields
//   merge_byte : per-byte read-modify-write select
package wb_ram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RMW_WAIT,
      WRITE,
      ACK
   } state_t;

   function automatic int log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic logic [7:0] merge_byte(input logic       sel,
                                             input logic [7:0] new_byte,
                                             input logic [7:0] old_byte);
      return sel ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/wb_ram_bridge.sv
// rtl/wb_ram_bridge.sv - Wishbone slave bridge onto a synchronous-read RAM
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   wbs_*_i / wbs_*_o : Wishbone slave (byte address, byte selects, data, ack)
//   ram_r_addr_o      : RAM read address, combinational from the word index
//   ram_data_i        : RAM read data, valid one cycle after the read address
//   ram_we_o, ram_w_addr_o, ram_data_o : registered RAM write port
module wb_ram_bridge
   import wb_ram_pkg::*;
#(
   parameter int RAM_WORDS_SIZE  = 256,
   parameter int RAM_WORDS_WIDTH = 32,
   localparam int AW   = log2(RAM_WORDS_SIZE),
   localparam int SELW = RAM_WORDS_WIDTH / 8,
   localparam int BO   = log2(SELW)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wbs_cyc_i,
   input  logic                       wbs_stb_i,
   input  logic                       wbs_we_i,
   input  logic [SELW-1:0]            wbs_sel_i,
   input  logic [31:0]                wbs_adr_i,
   input  logic [RAM_WORDS_WIDTH-1:0] wbs_dat_i,
   output logic [RAM_WORDS_WIDTH-1:0] wbs_dat_o,
   output logic                       wbs_ack_o,
   output logic                       ram_we_o,
   output logic [AW-1:0]              ram_w_addr_o,
   output logic [RAM_WORDS_WIDTH-1:0] ram_data_o,
   output logic [AW-1:0]              ram_r_addr_o,
   input  logic [RAM_WORDS_WIDTH-1:0] ram_data_i
);

   state_t                     state, state_next;
   logic                       req;
   logic                       sel_full, sel_none;
   logic [AW-1:0]              word_idx;
   logic [RAM_WORDS_WIDTH-1:0] merged;

   logic                       ack_d, we_d;
   logic [AW-1:0]              waddr_d;
   logic [RAM_WORDS_WIDTH-1:0] wdata_d, rdata_d;

   // Upper address bits are deliberately ignored, so addresses alias.
   logic unused_adr;
   assign unused_adr = ^wbs_adr_i;

   assign req          = wbs_cyc_i & wbs_stb_i;
   assign word_idx     = wbs_adr_i[BO+AW-1:BO];
   assign ram_r_addr_o = word_idx;
   assign sel_full     = &wbs_sel_i;
   assign sel_none     = ~|wbs_sel_i;

   always_comb begin
      merged = '0;
      for (int i = 0; i < SELW; i++) begin
         merged[8*i +: 8] = merge_byte(wbs_sel_i[i], wbs_dat_i[8*i +: 8], ram_data_i[8*i +: 8]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (!wbs_we_i)     state_next = RD_WAIT;
               else if (sel_full) state_next = WRITE;
               else if (sel_none) state_next = ACK;
               else               state_next = RMW_WAIT;
            end
         end
         RD_WAIT:  state_next = wbs_cyc_i ? ACK   : IDLE;
         RMW_WAIT: state_next = wbs_cyc_i ? WRITE : IDLE;
         // The RAM write is already issued; losing cyc only skips the ack.
         WRITE:    state_next = wbs_cyc_i ? ACK   : IDLE;
         ACK:      state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Next values of the registered outputs; ack_d is only set on entry to ACK.
   always_comb begin
      ack_d   = 1'b0;
      we_d    = 1'b0;
      waddr_d = ram_w_addr_o;
      wdata_d = ram_data_o;
      rdata_d = wbs_dat_o;
      case (state)
         IDLE: begin
            if (req && wbs_we_i) begin
               waddr_d = word_idx;
               if (sel_full) begin
                  we_d    = 1'b1;
                  wdata_d = wbs_dat_i;
               end else if (sel_none) begin
                  ack_d = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            if (wbs_cyc_i) begin
               rdata_d = ram_data_i;
               ack_d   = 1'b1;
            end
         end
         RMW_WAIT: begin
            if (wbs_cyc_i) begin
               wdata_d = merged;
               we_d    = 1'b1;
            end
         end
         WRITE: begin
            ack_d = wbs_cyc_i;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wbs_ack_o    <= 1'b0;
         ram_we_o     <= 1'b0;
         ram_w_addr_o <= '0;
         ram_data_o   <= '0;
         wbs_dat_o    <= '0;
      end else begin
         wbs_ack_o    <= ack_d;
         ram_we_o     <= we_d;
         ram_w_addr_o <= waddr_d;
         ram_data_o   <= wdata_d;
         wbs_dat_o    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_wb_ram_bridge.sv
// tb/tb_wb_ram_bridge.sv - directed self-checking bench for wb_ram_bridge
module tb_wb_ram_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;
   logic        ram_we_o;
   logic [7:0]  ram_w_addr_o, ram_r_addr_o;
   logic [31:0] ram_data_o;
   logic [31:0] ram_data_i;

   logic [31:0] mem [256];

   int n_checks = 0;
   int n_pass   = 0;
   int ack_count = 0;
   int we_count  = 0;
   int consec_ack = 0;
   logic prev_ack = 1'b0;

   always #5 clk_i = ~clk_i;

   wb_ram_bridge dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wbs_cyc_i    (wbs_cyc_i),
      .wbs_stb_i    (wbs_stb_i),
      .wbs_we_i     (wbs_we_i),
      .wbs_sel_i    (wbs_sel_i),
      .wbs_adr_i    (wbs_adr_i),
      .wbs_dat_i    (wbs_dat_i),
      .wbs_dat_o    (wbs_dat_o),
      .wbs_ack_o    (wbs_ack_o),
      .ram_we_o     (ram_we_o),
      .ram_w_addr_o (ram_w_addr_o),
      .ram_data_o   (ram_data_o),
      .ram_r_addr_o (ram_r_addr_o),
      .ram_data_i   (ram_data_i)
   );

   // Synchronous-read RAM standing in for generic_ram.
   always @(posedge clk_i) begin
      if (ram_we_o) mem[ram_w_addr_o] <= ram_data_o;
      ram_data_i <= mem[ram_r_addr_o];
   end

   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (wbs_ack_o) ack_count++;
         if (wbs_ack_o && prev_ack) consec_ack++;
         if (ram_we_o) we_count++;
         prev_ack = wbs_ack_o;
      end else begin
         prev_ack = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Issues one transfer and returns the cycle ack was seen in (0 = none).
   task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, output int ack_cyc);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
      ack_cyc = 0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk_i); #1;
         if (wbs_ack_o) begin
            ack_cyc = n;
            break;
         end
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   int ac;
   int a0, w0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      rst_i = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ack",   {31'b0, wbs_ack_o}, 32'h0);
      check("rst_we",    {31'b0, ram_we_o},  32'h0);
      check("rst_dat_o", wbs_dat_o,          32'h0);
      check("rst_wdata", ram_data_o,         32'h0);
      check("rst_waddr", {24'b0, ram_w_addr_o}, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;

      wbs_adr_i = 32'h14; #1;
      check("raddr_comb_14", {24'b0, ram_r_addr_o}, 32'h05);
      wbs_adr_i = 32'h7FC; #1;
      check("raddr_comb_7fc", {24'b0, ram_r_addr_o}, 32'hFF);

      // Read of preloaded word 5.
      mem[5] = 32'hDEADBEEF;
      xfer(1'b0, 4'hF, 32'h14, 32'h0, ac);
      check("rd_ack_cycle", ac, 2);
      check("rd_data", wbs_dat_o, 32'hDEADBEEF);

      // Full-word write then read back.
      w0 = we_count;
      xfer(1'b1, 4'hF, 32'h20, 32'h12345678, ac);
      check("wr_full_ack_cycle", ac, 2);
      check("wr_full_we_pulses", we_count - w0, 1);
      check("wr_full_mem", mem[8], 32'h12345678);
      xfer(1'b0, 4'hF, 32'h20, 32'h0, ac);
      check("wr_full_readback", wbs_dat_o, 32'h12345678);

      // Partial write merges bytes 0 and 2.
      mem[8] = 32'hAABBCCDD;
      xfer(1'b1, 4'b0101, 32'h20, 32'h11223344, ac);
      check("wr_part_ack_cycle", ac, 3);
      xfer(1'b0, 4'hF, 32'h20, 32'h0, ac);
      check("wr_part_readback", wbs_dat_o, 32'hAA22CC44);

      // Empty byte-select write: ack only, no RAM write.
      w0 = we_count;
      xfer(1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, ac);
      check("wr_none_ack_cycle", ac, 1);
      check("wr_none_we_pulses", we_count - w0, 0);
      check("wr_none_mem", mem[8], 32'hAA22CC44);

      // Partial write aborted in RMW_WAIT.
      a0 = ack_count; w0 = we_count;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_sel_i = 4'b0011; wbs_adr_i = 32'h20; wbs_dat_i = 32'h55555555;
      @(posedge clk_i); #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      check("abort_acks", ack_count - a0, 0);
      check("abort_we_pulses", we_count - w0, 0);
      xfer(1'b0, 4'hF, 32'h20, 32'h0, ac);
      check("abort_readback", wbs_dat_o, 32'hAA22CC44);

      // Address aliasing: bit 10 lies above the word index.
      xfer(1'b0, 4'hF, 32'h420, 32'h0, ac);
      check("alias_read", wbs_dat_o, 32'hAA22CC44);

      // Full write with cyc dropped in WRITE still lands, without an ack.
      a0 = ack_count; w0 = we_count;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_sel_i = 4'hF; wbs_adr_i = 32'h30; wbs_dat_i = 32'hCAFE0001;
      @(posedge clk_i); #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("wr_drop_mem", mem[12], 32'hCAFE0001);
      check("wr_drop_acks", ack_count - a0, 0);
      check("wr_drop_we_pulses", we_count - w0, 1);

      // Reset pulsed during RD_WAIT.
      mem[3] = 32'h0BADF00D;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_sel_i = 4'hF; wbs_adr_i = 32'h0C;
      @(posedge clk_i); #1;
      rst_i = 1'b1; #1;
      check("midrst_dat_o", wbs_dat_o, 32'h0);
      check("midrst_ack", {31'b0, wbs_ack_o}, 32'h0);
      check("midrst_we", {31'b0, ram_we_o}, 32'h0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      a0 = ack_count; w0 = we_count;
      rst_i = 1'b0;
      xfer(1'b0, 4'hF, 32'h0C, 32'h0, ac);
      check("postrst_ack_cycle", ac, 2);
      check("postrst_data", wbs_dat_o, 32'h0BADF00D);
      repeat (3) @(posedge clk_i);
      #1;
      check("postrst_acks", ack_count - a0, 1);
      check("postrst_we_pulses", we_count - w0, 0);

      check("no_consecutive_ack", consec_ack, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
